regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised general-purpose register file for the MIPS pipeline, successor to the single-configuration 32×32 file. It adds a configurable read-port count, same-cycle write-to-read bypass and a per-register pending (scoreboard) bit that tracks outstanding producers. It sits in the decode stage: decode reads operands and reserves destinations, and writeback writes results and releases reservations.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth is 2**ADDR_W
- NREAD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 hardwired to zero and never pending
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- we  in  1  writeback write enable
- waddr  in  ADDR_W  writeback destination
- wdata  in  DATA_W  writeback data
- raddr  in  NREAD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W]
- rdata  out  NREAD*DATA_W  read data; port k at bits [k*DATA_W +: DATA_W]
- rbusy  out  NREAD  port k operand has an outstanding producer
- rsv_en  in  1  reserve destination (decode issues a register-writing instruction)
- rsv_addr  in  ADDR_W  destination being reserved
- flush  in  1  synchronous clear of all pending bits (pipeline flush)
- pend_cnt  out  ADDR_W+1  number of pending bits currently set

## Operation
- Storage: 2**ADDR_W × DATA_W registers plus pending vector P[2**ADDR_W].
- Write: on the posedge with we=1, R[waddr] <= wdata and P[waddr] <= 0, unless the same edge sets P[waddr] (see priority). A write to register 0 with ZERO_REG=1 is discarded.
- Read (combinational, per port k): if raddr_k==0 and ZERO_REG, rdata_k=0. Else if we and waddr==raddr_k, rdata_k=wdata (bypass). Else rdata_k=R[raddr_k].
- rbusy_k = P[raddr_k] & ~(we & waddr==raddr_k). A same-cycle writeback releases the operand. Forced to 0 for address 0 when ZERO_REG.
- Reserve: on the posedge with rsv_en=1, P[rsv_addr] <= 1. Ignored for address 0 when ZERO_REG.
- Priority per bit, highest first: rst, flush (clears all bits, including any same-cycle reserve), reserve, write-release.
- Same edge with we and rsv_en on the same address: the data is written and P stays 1 (a new producer supersedes the old one).
- Reserving an already-pending register keeps P=1. There is no nesting count.
- A write to a non-pending register is legal: data is written and P stays 0.
- pend_cnt is a registered population count, updated every edge as (next P) popcount. Its range is 0..2**ADDR_W, so it is ADDR_W+1 bits wide and cannot overflow.

## Timing
- Read latency 0 (combinational from raddr, we, waddr, wdata). Write and reserve effects are visible from the cycle after the edge.
- rbusy is combinational from raddr, P, we and waddr.
- Reset (asynchronous assert, synchronous-safe deassert): all R=0, all P=0, pend_cnt=0. rdata reads 0 for any address and rbusy=0 once raddr settles.
- If rst asserts mid-cycle alongside we/rsv_en, reset wins and no write or reserve occurs.
- flush is synchronous. It does not block a same-edge write to R.

## Structure
- Shared package regfile_pkg: default DATA_W/ADDR_W constants, the ZERO address constant and a popcount function sized by parameter.
- One sub-module, regfile_sb_port: single read-port mux with zero handling, bypass and busy logic, instantiated NREAD times in a generate loop.
- The storage array and pending vector stay in the top-level module.

## Test plan
- Reset, then read all 32 addresses on both ports -> rdata=0, rbusy=0, pend_cnt=0.
- Write R5=0xDEADBEEF while raddr0=5 in the same cycle -> rdata0=0xDEADBEEF (bypass). Next cycle R5 reads 0xDEADBEEF with no write active.
- Write 0x1234 to R0 with ZERO_REG=1, then read R0 -> 0. Reserve R0 -> pend_cnt stays 0 and rbusy stays 0.
- Reserve R7 -> next cycle rbusy0=1 for raddr0=7 and pend_cnt=1. Writeback R7=0x55 -> rbusy0=0 that cycle, P7=0 after the edge, pend_cnt=0.
- Same edge: we to R9 (0xAA) and rsv_en to R9 -> R9=0xAA and rbusy stays 1. Reserve R3/R4/R6, then flush -> pend_cnt=0 and all rbusy=0.
- Assert rst asynchronously mid-cycle with we=1, waddr=12 and 3 bits pending -> R12=0, pend_cnt=0 immediately, and no write after deassert.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
// No timing of its own; no flow control.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_ADDR  = 0;

  // Widest pending vector the popcount helper accepts (ADDR_W up to 8).
  localparam int POP_MAX = 256;

  function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < POP_MAX; i++) begin
      if (v[i]) cnt++;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/regfile_sb_port.sv
// One read port: zero-register handling, writeback bypass and busy flag.
// Latency 0 (pure combinational); no backpressure.
module regfile_sb_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0] raddr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rd_q,
  input  logic              pend_q,
  output logic [DATA_W-1:0] rdata,
  output logic              rbusy
);

  logic is_zero;
  logic hit;

  assign is_zero = (ZERO_REG != 0) && (raddr == ADDR_W'(ZERO_ADDR));
  assign hit     = we && (waddr == raddr);

  always_comb begin
    rdata = rd_q;
    if (is_zero)  rdata = '0;
    else if (hit) rdata = wdata;
  end

  // A same-cycle writeback is the producer the operand was waiting on.
  assign rbusy = pend_q & ~hit & ~is_zero;

endmodule

// File: rtl/regfile_sb.sv
// Register file with NREAD bypassed read ports and per-register pending bits.
// Read latency 0, write/reserve visible next cycle; no backpressure.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [NREAD*ADDR_W-1:0] raddr,
  output logic [NREAD*DATA_W-1:0] rdata,
  output logic [NREAD-1:0]        rbusy,
  input  logic                    rsv_en,
  input  logic [ADDR_W-1:0]       rsv_addr,
  input  logic                    flush,
  output logic [ADDR_W:0]         pend_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [DEPTH-1:0]  pend_nxt;
  logic [POP_MAX-1:0] pend_ext;
  logic              wen;
  logic              rsv_ok;

  assign wen    = we && !((ZERO_REG != 0) && (waddr == ADDR_W'(ZERO_ADDR)));
  assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == ADDR_W'(ZERO_ADDR)));

  // Later assignments win: flush over reserve over write-release.
  always_comb begin
    pend_nxt = pending;
    if (wen)    pend_nxt[waddr]    = 1'b0;
    if (rsv_ok) pend_nxt[rsv_addr] = 1'b1;
    if (flush)  pend_nxt           = '0;
  end

  always_comb begin
    pend_ext = '0;
    pend_ext[DEPTH-1:0] = pend_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wen) begin
      regs[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      pending  <= pend_nxt;
      pend_cnt <= (ADDR_W+1)'(popcount(pend_ext));
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_port
    logic [ADDR_W-1:0] ra;
    assign ra = raddr[k*ADDR_W +: ADDR_W];

    regfile_sb_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_port (
      .raddr  (ra),
      .we     (we),
      .waddr  (waddr),
      .wdata  (wdata),
      .rd_q   (regs[ra]),
      .pend_q (pending[ra]),
      .rdata  (rdata[k*DATA_W +: DATA_W]),
      .rbusy  (rbusy[k])
    );
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios plus random traffic against an array model.
module tb_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0] rbusy;
  logic          rsv_en;
  logic [AW-1:0] rsv_addr;
  logic          flush;
  logic [AW:0]   pend_cnt;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] mreg [DEPTH];
  bit            mpend [DEPTH];

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: register 0 reads zero and is never pending; flush beats reserve beats release.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mreg[i]  = '0;
        mpend[i] = 1'b0;
      end
    end else begin
      if (we && waddr != 0) begin
        mreg[waddr]  = wdata;
        mpend[waddr] = 1'b0;
      end
      if (rsv_en && rsv_addr != 0) mpend[rsv_addr] = 1'b1;
      if (flush) for (int i = 0; i < DEPTH; i++) mpend[i] = 1'b0;
    end
  end

  function automatic logic [DW-1:0] exp_rdata(input int a);
    if (a == 0) return '0;
    if (we && int'(waddr) == a) return wdata;
    return mreg[a];
  endfunction

  function automatic logic exp_busy(input int a);
    if (a == 0) return 1'b0;
    return mpend[a] && !(we && int'(waddr) == a);
  endfunction

  function automatic int exp_cnt();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(mpend[i]);
    return c;
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      for (int k = 0; k < NR; k++) begin
        int a;
        a = int'(raddr[k*AW +: AW]);
        chk($sformatf("model rdata%0d", k), 64'(rdata[k*DW +: DW]), 64'(exp_rdata(a)));
        chk($sformatf("model rbusy%0d", k), 64'(rbusy[k]), 64'(exp_busy(a)));
      end
      chk("model pend_cnt", 64'(pend_cnt), 64'(exp_cnt()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; rsv_en = 1'b0; flush = 1'b0;
  endtask

  task automatic reserve(input int a);
    rsv_en = 1'b1; rsv_addr = AW'(a);
    step();
    rsv_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
    step(); step();
    rst = 1'b0;
    #2;

    // Reset contents on every address, both ports.
    for (int a = 0; a < DEPTH; a++) begin
      raddr = {AW'(DEPTH-1-a), AW'(a)};
      #0.5;
      chk("reset rdata", 64'(rdata), 64'd0);
      chk("reset rbusy", 64'(rbusy), 64'd0);
    end
    chk("reset pend_cnt", 64'(pend_cnt), 64'd0);

    // Bypass then stored value.
    step();
    we = 1'b1; waddr = 5; wdata = 32'hDEADBEEF; raddr = {AW'(0), AW'(5)};
    #2 chk("bypass rdata0", 64'(rdata[DW-1:0]), 64'hDEADBEEF);
    step(); idle();
    #2 chk("stored R5", 64'(rdata[DW-1:0]), 64'hDEADBEEF);

    // Register 0 is hardwired.
    step();
    we = 1'b1; waddr = 0; wdata = 32'h1234; raddr = '0;
    #2 chk("R0 write bypass blocked", 64'(rdata[DW-1:0]), 64'd0);
    step(); idle();
    #2 chk("R0 read", 64'(rdata[DW-1:0]), 64'd0);
    reserve(0);
    #2 chk("R0 reserve cnt", 64'(pend_cnt), 64'd0);
    chk("R0 reserve busy", 64'(rbusy[0]), 64'd0);

    // Reserve then writeback release.
    reserve(7);
    raddr = {AW'(0), AW'(7)};
    #2 chk("R7 busy", 64'(rbusy[0]), 64'd1);
    chk("R7 cnt", 64'(pend_cnt), 64'd1);
    we = 1'b1; waddr = 7; wdata = 32'h55;
    #1 chk("R7 release same cycle", 64'(rbusy[0]), 64'd0);
    step(); idle();
    #2 chk("R7 cnt after wb", 64'(pend_cnt), 64'd0);
    chk("R7 busy after wb", 64'(rbusy[0]), 64'd0);
    chk("R7 data", 64'(rdata[DW-1:0]), 64'h55);

    // Write and reserve on the same register and edge.
    we = 1'b1; waddr = 9; wdata = 32'hAA; rsv_en = 1'b1; rsv_addr = 9;
    step(); idle();
    raddr = {AW'(3), AW'(9)};
    #2 chk("R9 data", 64'(rdata[DW-1:0]), 64'hAA);
    chk("R9 busy", 64'(rbusy[0]), 64'd1);
    reserve(3); reserve(4); reserve(6);
    #2 chk("cnt before flush", 64'(pend_cnt), 64'd4);
    flush = 1'b1; rsv_en = 1'b1; rsv_addr = 10;
    step(); idle();
    #2 chk("cnt after flush", 64'(pend_cnt), 64'd0);
    chk("busy after flush", 64'(rbusy), 64'd0);

    // Asynchronous reset racing a writeback.
    reserve(3); reserve(4); reserve(6);
    #2 chk("cnt before rst", 64'(pend_cnt), 64'd3);
    we = 1'b1; waddr = 12; wdata = 32'hFFFF0000; raddr = {AW'(3), AW'(12)};
    #1 rst = 1'b1;
    #1 chk("async rst cnt", 64'(pend_cnt), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; idle();
    #2 chk("R12 after rst", 64'(rdata[DW-1:0]), 64'd0);
    chk("busy after rst", 64'(rbusy), 64'd0);
    step();
    #2 chk("cnt after rst release", 64'(pend_cnt), 64'd0);

    // Random traffic, addresses biased to a small window so bypass/reserve collide.
    for (int n = 0; n < 3000; n++) begin
      bit narrow;
      narrow   = ($urandom_range(0, 3) != 0);
      we       = ($urandom_range(0, 1) == 1);
      waddr    = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
      wdata    = $urandom;
      rsv_en   = ($urandom_range(0, 9) < 4);
      rsv_addr = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
      flush    = ($urandom_range(0, 49) == 0);
      for (int k = 0; k < NR; k++)
        raddr[k*AW +: AW] = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
      step();
    end
    idle();
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
